if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch unit with a credit-checked prefetch queue.
//               Issues sequential memory reads, queues the returned words
//               with their addresses, and flushes on a redirect while
//               discarding the responses still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready
);

    localparam int c_ptr_w = $clog2(QDEPTH);
    localparam int c_cnt_w = $clog2(QDEPTH + 1);
    localparam int c_sum_w = c_cnt_w + 2;
    localparam logic [c_sum_w-1:0] c_depth = c_sum_w'(QDEPTH);

    logic [PC_W-1:0]    r_fetch_pc;
    logic [PC_W-1:0]    r_resp_pc;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_stale;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [INSTR_W-1:0] r_instr_q [QDEPTH];
    logic [PC_W-1:0]    r_pc_q    [QDEPTH];

    logic [c_sum_w-1:0] w_inflight;
    logic               w_grant;
    logic               w_live_rsp;
    logic               w_stale_rsp;
    logic               w_push;
    logic               w_pop;

    // Request credit and handshake decode. Stale responses also hold a
    // credit so that stale + outstanding can never exceed QDEPTH, which
    // keeps every counter inside its 0..QDEPTH range across any sequence
    // of back-to-back redirects.
    always_comb begin
        w_inflight  = c_sum_w'(r_count) + c_sum_w'(r_outstanding) + c_sum_w'(r_stale);
        mem_req     = !rst && !redirect && (w_inflight < c_depth);
        mem_addr    = r_fetch_pc;
        w_grant     = mem_req && mem_gnt;
        w_stale_rsp = mem_rvalid && (r_stale != '0);
        w_live_rsp  = mem_rvalid && (r_stale == '0);
        w_push      = w_live_rsp && !redirect;
        out_valid   = (r_count != '0);
        w_pop       = out_valid && out_ready;
        out_instr   = r_instr_q[r_rptr];
        out_pc      = r_pc_q[r_rptr];
    end

    // Fetch address, response address tracking, queue pointers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else if (redirect) begin
            // Everything still in flight (minus a response landing now)
            // becomes stale; the queue is emptied.
            r_fetch_pc    <= redirect_pc;
            r_resp_pc     <= redirect_pc;
            r_count       <= '0;
            r_outstanding <= '0;
            r_stale       <= r_stale + r_outstanding + c_cnt_w'(w_grant)
                             - c_cnt_w'(mem_rvalid);
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + PC_W'(1);
            end
            r_outstanding <= r_outstanding + c_cnt_w'(w_grant) - c_cnt_w'(w_live_rsp);
            r_stale       <= r_stale - c_cnt_w'(w_stale_rsp);
            r_count       <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            if (w_push) begin
                r_wptr    <= r_wptr + c_ptr_w'(1);
                r_resp_pc <= r_resp_pc + PC_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
        end
    end

    // Queue storage: instruction word paired with the address it came from.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wptr] <= mem_rdata;
            r_pc_q[r_wptr]    <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire
